// File: rtl/vpu_pkg.sv
// rtl/vpu_pkg.sv - shared owner/state encodings and default widths for the VPU memory arbiter
package vpu_pkg;

  localparam int DEF_ADDR_W = 19;
  localparam int DEF_DATA_W = 16;
  localparam int DEF_LVL_W  = 9;

  typedef enum logic {
    OWN_BG  = 1'b0,
    OWN_SPR = 1'b1
  } owner_e;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_ISSUE = 1'b1
  } arb_state_e;

endpackage

// File: rtl/vpu_mem_arbiter_if.sv
// rtl/vpu_mem_arbiter_if.sv - requester, frame and memory-port signals of the VPU memory arbiter
interface vpu_mem_arbiter_if
  import vpu_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int LVL_W  = DEF_LVL_W
);

  logic              new_frame;
  logic [LVL_W-1:0]  bg_fifo_level;
  logic              bg_req;
  logic              spr_req;
  logic [ADDR_W-1:0] bg_addr;
  logic [ADDR_W-1:0] spr_addr;
  logic              bg_gnt;
  logic              spr_gnt;
  logic              bg_rvalid;
  logic              spr_rvalid;
  logic [DATA_W-1:0] rdata;
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_ack;
  logic              mem_rvalid;
  logic [DATA_W-1:0] mem_rdata;
  logic              err_orphan;

  modport master (
    input  new_frame, bg_fifo_level, bg_req, spr_req, bg_addr, spr_addr,
    input  mem_ack, mem_rvalid, mem_rdata,
    output bg_gnt, spr_gnt, bg_rvalid, spr_rvalid, rdata,
    output mem_req, mem_addr, err_orphan
  );

  modport slave (
    output new_frame, bg_fifo_level, bg_req, spr_req, bg_addr, spr_addr,
    output mem_ack, mem_rvalid, mem_rdata,
    input  bg_gnt, spr_gnt, bg_rvalid, spr_rvalid, rdata,
    input  mem_req, mem_addr, err_orphan
  );

endinterface

// File: rtl/vpu_mem_arbiter_owner_fifo.sv
// rtl/vpu_mem_arbiter_owner_fifo.sv - 1-bit owner-tag FIFO tracking outstanding reads in issue order
module owner_fifo #(
  parameter  int DEPTH = 4,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             din,
  input  logic             pop,
  output logic             dout,
  output logic             empty,
  output logic             full,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  logic [DEPTH-1:0] mem;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == DEPTH_C);
  assign dout    = mem[rd_ptr];
  assign do_pop  = pop && !empty;
  // A push into a full FIFO is only safe when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/vpu_mem_arbiter.sv
// rtl/vpu_mem_arbiter.sv - shares the VPU read port between background and sprite fetchers
module vpu_mem_arbiter
  import vpu_pkg::*;
#(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int LVL_W      = DEF_LVL_W,
  parameter int BG_LOW_WM  = 16,
  parameter int MAX_OUT    = 4,
  parameter int SPR_BUDGET = 256
) (
  input logic               clk,
  input logic               rst,
  vpu_mem_arbiter_if.master bus
);

  localparam int CNT_W = $clog2(MAX_OUT + 1);
  localparam int BUD_W = $clog2(SPR_BUDGET + 1);
  localparam logic [LVL_W-1:0] WM_LVL   = LVL_W'(BG_LOW_WM);
  localparam logic [CNT_W-1:0] OUT_LIM  = CNT_W'(MAX_OUT);
  localparam logic [BUD_W-1:0] BUD_INIT = BUD_W'(SPR_BUDGET);

  arb_state_e        state, state_nxt;
  owner_e            cur_owner, last_owner, pick;
  logic              issue;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [BUD_W-1:0]  spr_left;
  logic              bg_rv_q, spr_rv_q, err_q;
  logic [DATA_W-1:0] rdata_q;

  logic              bg_elig, spr_elig, bg_urgent;
  logic              ack, pop;
  logic              fifo_head, fifo_empty, fifo_full_unused;
  logic [CNT_W-1:0]  outstanding;

  assign bg_elig   = bus.bg_req;
  assign spr_elig  = bus.spr_req && (spr_left != '0);
  assign bg_urgent = bus.bg_fifo_level < WM_LVL;
  assign ack       = (state == ST_ISSUE) && bus.mem_ack;
  assign pop       = bus.mem_rvalid && !fifo_empty;

  owner_fifo #(.DEPTH(MAX_OUT)) u_owner_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (ack),
    .din   (cur_owner),
    .pop   (pop),
    .dout  (fifo_head),
    .empty (fifo_empty),
    .full  (fifo_full_unused),
    .count (outstanding)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    issue     = 1'b0;
    // Urgent background first, then the lone requester, then whoever did not go last.
    if (bg_elig && (bg_urgent || !spr_elig || last_owner == OWN_SPR)) pick = OWN_BG;
    else                                                              pick = OWN_SPR;
    unique case (state)
      ST_IDLE: begin
        if ((bg_elig || spr_elig) && outstanding < OUT_LIM) begin
          state_nxt = ST_ISSUE;
          issue     = 1'b1;
        end
      end
      ST_ISSUE: begin
        if (bus.mem_ack) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_addr_q <= '0;
      cur_owner  <= OWN_BG;
      last_owner <= OWN_SPR;
      spr_left   <= BUD_INIT;
      bg_rv_q    <= 1'b0;
      spr_rv_q   <= 1'b0;
      rdata_q    <= '0;
      err_q      <= 1'b0;
    end else begin
      if (issue) begin
        cur_owner  <= pick;
        mem_addr_q <= (pick == OWN_BG) ? bus.bg_addr : bus.spr_addr;
      end
      if (ack) last_owner <= cur_owner;
      // Frame reload beats a coincident sprite decrement.
      if (bus.new_frame)                  spr_left <= BUD_INIT;
      else if (ack && cur_owner == OWN_SPR) spr_left <= spr_left - 1'b1;
      bg_rv_q  <= pop && (fifo_head == OWN_BG);
      spr_rv_q <= pop && (fifo_head == OWN_SPR);
      if (pop) rdata_q <= bus.mem_rdata;
      if (bus.mem_rvalid && fifo_empty) err_q <= 1'b1;
    end
  end

  assign bus.mem_req    = (state == ST_ISSUE);
  assign bus.mem_addr   = mem_addr_q;
  assign bus.bg_gnt     = ack && (cur_owner == OWN_BG);
  assign bus.spr_gnt    = ack && (cur_owner == OWN_SPR);
  assign bus.bg_rvalid  = bg_rv_q;
  assign bus.spr_rvalid = spr_rv_q;
  assign bus.rdata      = rdata_q;
  assign bus.err_orphan = err_q;

endmodule

// File: tb/tb_vpu_mem_arbiter.sv
// tb/tb_vpu_mem_arbiter.sv - self-checking bench for vpu_mem_arbiter against a transaction-level model
module tb_vpu_mem_arbiter;
  import vpu_pkg::*;

  localparam int AW = 19;
  localparam int DW = 16;
  localparam int LW = 9;
  localparam int WM = 16;
  localparam int MO = 4;
  localparam int SB = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  vpu_mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW), .LVL_W(LW)) bus ();

  vpu_mem_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .LVL_W(LW),
    .BG_LOW_WM(WM), .MAX_OUT(MO), .SPR_BUDGET(SB)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Memory side: manual return pulses, or a responder answering one cycle after each accept.
  logic          auto_rsp = 1'b0;
  logic          man_rv   = 1'b0;
  logic [DW-1:0] man_rd   = '0;
  logic          rsp_v    = 1'b0;
  logic [DW-1:0] rsp_d    = 16'hA001;
  always @(posedge clk) begin
    rsp_v <= auto_rsp && bus.mem_req && bus.mem_ack;
    if (rsp_v) rsp_d <= rsp_d + 16'd1;
  end
  assign bus.mem_rvalid = auto_rsp ? rsp_v : man_rv;
  assign bus.mem_rdata  = auto_rsp ? rsp_d : man_rd;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: one read presented at a time, tags queued in issue order.
  logic          m_pres;
  logic [AW-1:0] m_addr;
  int            m_own, m_last, m_budget;
  int            q[$];
  logic          m_err, e_bgv, e_sprv;
  logic [DW-1:0] e_rdata;

  always @(posedge clk) begin : model
    int   n_out, w;
    logic be, se;
    if (rst) begin
      m_pres = 1'b0; m_addr = '0; m_own = 0; m_last = 1; m_budget = SB;
      q.delete(); m_err = 1'b0; e_bgv = 1'b0; e_sprv = 1'b0; e_rdata = '0;
    end else begin
      n_out  = q.size();
      e_bgv  = 1'b0;
      e_sprv = 1'b0;
      if (bus.mem_rvalid) begin
        if (n_out == 0) m_err = 1'b1;
        else begin
          w = q.pop_front();
          e_bgv = (w == 0); e_sprv = (w == 1); e_rdata = bus.mem_rdata;
        end
      end
      if (m_pres) begin
        if (bus.mem_ack) begin
          q.push_back(m_own);
          m_last = m_own;
          if (m_own == 1) m_budget--;
          m_pres = 1'b0;
        end
      end else if (n_out < MO) begin
        be = bus.bg_req;
        se = bus.spr_req && (m_budget > 0);
        if (be && bus.bg_fifo_level < WM) w = 0;
        else if (be && se)                w = 1 - m_last;
        else if (be)                      w = 0;
        else if (se)                      w = 1;
        else                              w = -1;
        if (w >= 0) begin
          m_pres = 1'b1;
          m_own  = w;
          m_addr = (w == 0) ? bus.bg_addr : bus.spr_addr;
        end
      end
      if (bus.new_frame) m_budget = SB;
    end
  end

  logic chk_en = 1'b0;
  int   n_bg_gnt = 0, n_spr_gnt = 0, n_bg_rv = 0, n_spr_rv = 0;
  int   glog[$];

  always @(negedge clk) begin
    if (chk_en) begin
      check("mem_req",    bus.mem_req,    m_pres);
      check("mem_addr",   bus.mem_addr,   m_addr);
      check("bg_gnt",     bus.bg_gnt,     m_pres && bus.mem_ack && m_own == 0);
      check("spr_gnt",    bus.spr_gnt,    m_pres && bus.mem_ack && m_own == 1);
      check("bg_rvalid",  bus.bg_rvalid,  e_bgv);
      check("spr_rvalid", bus.spr_rvalid, e_sprv);
      check("rdata",      bus.rdata,      e_rdata);
      check("err_orphan", bus.err_orphan, m_err);
      if (bus.bg_gnt)     begin n_bg_gnt++;  glog.push_back(0); end
      if (bus.spr_gnt)    begin n_spr_gnt++; glog.push_back(1); end
      if (bus.bg_rvalid)  n_bg_rv++;
      if (bus.spr_rvalid) n_spr_rv++;
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic reset_pulse();
    rst = 1'b1;
    step(1);
    rst = 1'b0;
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) begin
      man_rv = 1'b1;
      man_rd = DW'(32'hA001 + i);
      step(1);
    end
    man_rv = 1'b0;
    step(2);
  endtask

  int b0, b1, g0;

  initial begin
    bus.new_frame = 1'b0; bus.bg_fifo_level = 9'd100;
    bus.bg_req = 1'b0; bus.spr_req = 1'b0;
    bus.bg_addr = 19'h12345; bus.spr_addr = 19'h6789A; bus.mem_ack = 1'b0;
    rst = 1'b1;
    step(2);
    chk_en = 1'b1;
    check("reset_mem_req",  bus.mem_req, 0);
    check("reset_mem_addr", bus.mem_addr, 0);
    check("reset_err",      bus.err_orphan, 0);
    check("reset_rvalid",   {bus.bg_rvalid, bus.spr_rvalid}, 0);
    check("reset_rdata",    bus.rdata, 0);
    rst = 1'b0;

    // Background alone: issue every other cycle, stall at four outstanding.
    b0 = n_bg_gnt;
    bus.bg_req = 1'b1; bus.mem_ack = 1'b1;
    step(12);
    check("bg_only_gnts", n_bg_gnt - b0, 4);
    check("bg_only_addr", bus.mem_addr, 19'h12345);
    bus.bg_req = 1'b0;
    b0 = n_bg_rv;
    drain(4);
    check("bg_only_rvalids", n_bg_rv - b0, 4);
    check("bg_only_rdata",   bus.rdata, 16'hA004);

    // Both requesting, not urgent: strict alternation starting with background.
    reset_pulse();
    g0 = glog.size();
    bus.bg_req = 1'b1; bus.spr_req = 1'b1;
    step(8);
    bus.bg_req = 1'b0; bus.spr_req = 1'b0;
    check("alt_count", glog.size() - g0, 4);
    for (int i = 0; i < 4; i++) check("alt_order", glog[g0 + i], i % 2);
    b0 = n_bg_rv; b1 = n_spr_rv;
    drain(4);
    check("alt_bg_rvalids",  n_bg_rv - b0, 2);
    check("alt_spr_rvalids", n_spr_rv - b1, 2);

    // Urgent background starves sprites.
    reset_pulse();
    bus.bg_fifo_level = 9'd10;
    b0 = n_bg_gnt; b1 = n_spr_gnt;
    bus.bg_req = 1'b1; bus.spr_req = 1'b1;
    step(8);
    bus.bg_req = 1'b0; bus.spr_req = 1'b0;
    check("urgent_bg_gnts",  n_bg_gnt - b0, 4);
    check("urgent_spr_gnts", n_spr_gnt - b1, 0);
    drain(4);
    bus.bg_fifo_level = 9'd100;

    // Sprite budget, then reload on a new frame.
    reset_pulse();
    auto_rsp = 1'b1;
    b1 = n_spr_gnt;
    bus.spr_req = 1'b1;
    step(12);
    check("budget_first", n_spr_gnt - b1, 3);
    bus.new_frame = 1'b1;
    step(1);
    bus.new_frame = 1'b0;
    step(12);
    check("budget_reload", n_spr_gnt - b1, 6);
    bus.spr_req = 1'b0;
    step(3);

    // new_frame lands on the third sprite accept: reload wins.
    reset_pulse();
    b1 = n_spr_gnt;
    bus.spr_req = 1'b1;
    step(5);
    check("coinc_before", n_spr_gnt - b1, 2);
    bus.new_frame = 1'b1;
    step(1);
    bus.new_frame = 1'b0;
    step(16);
    check("coinc_total", n_spr_gnt - b1, 6);
    bus.spr_req = 1'b0;
    step(3);
    auto_rsp = 1'b0;

    // Reset while presenting with two reads outstanding.
    reset_pulse();
    bus.bg_req = 1'b1; bus.mem_ack = 1'b1;
    step(4);
    bus.mem_ack = 1'b0;
    step(1);
    check("pre_reset_req", bus.mem_req, 1);
    rst = 1'b1;
    step(1);
    check("reset_drops_req", bus.mem_req, 0);
    rst = 1'b0;
    bus.bg_req = 1'b0;
    step(1);
    b0 = n_bg_rv; b1 = n_spr_rv;
    man_rv = 1'b1; man_rd = 16'hBEEF;
    step(1);
    man_rv = 1'b0;
    step(2);
    check("orphan_flag",    bus.err_orphan, 1);
    check("orphan_no_rval", (n_bg_rv - b0) + (n_spr_rv - b1), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
